iterative_alu: RTL and testbench

ITERATIVE_ALU -- requirements
Module: iterative_alu

---
 rtl/iterative_alu.sv | 164 ++++++++++++++++
 tb/tb_iterative_alu.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/iterative_alu.sv
`default_nettype none
// ============================================================================
//  Module   : iterative_alu
//  Brief    : Multi-cycle ALU. Single-cycle arithmetic/logic ops, and shifts
//             done one bit per clock with a valid/ready handshake on both
//             the request and result sides.
//  Revision : 1.0  initial release
// ============================================================================
module iterative_alu #(
  parameter int XLEN    = 32,
  parameter int SHAMT_W = 5    // must equal log2(XLEN)
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [3:0]          alu_op,
  input  logic [XLEN-1:0]     src_a,
  input  logic [XLEN-1:0]     src_b,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [XLEN-1:0]     alu_result,
  output logic                alu_zero,
  output logic                alu_illegal
);

  localparam logic [3:0] OP_ADD  = 4'b0000;
  localparam logic [3:0] OP_SUB  = 4'b0001;
  localparam logic [3:0] OP_AND  = 4'b0010;
  localparam logic [3:0] OP_OR   = 4'b0011;
  localparam logic [3:0] OP_XOR  = 4'b0100;
  localparam logic [3:0] OP_SLT  = 4'b0101;
  localparam logic [3:0] OP_SLTU = 4'b0110;
  localparam logic [3:0] OP_SLL  = 4'b0111;
  localparam logic [3:0] OP_SRL  = 4'b1000;
  localparam logic [3:0] OP_SRA  = 4'b1001;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t               state;
  state_t               next_state;

  // Latched operation and working state. The result register doubles as the
  // shift working register, so no separate copy of src_a is kept.
  logic [3:0]           op_q;
  logic [XLEN-1:0]      result;
  logic [SHAMT_W-1:0]   count;
  logic                 illegal;

  logic [XLEN-1:0]      imm_result;
  logic                 imm_illegal;
  logic                 is_shift;
  logic [SHAMT_W-1:0]   shamt;
  logic                 start_shift;
  logic                 accept;

  assign shamt       = src_b[SHAMT_W-1:0];
  assign is_shift    = (alu_op == OP_SLL) || (alu_op == OP_SRL) || (alu_op == OP_SRA);
  assign start_shift = is_shift && (shamt != '0);
  assign accept      = in_valid && (state == IDLE);

  // Single-cycle result for every op; shifts by zero simply pass src_a.
  always_comb begin
    imm_result  = '0;
    imm_illegal = 1'b0;
    case (alu_op)
      OP_ADD:  imm_result = src_a + src_b;
      OP_SUB:  imm_result = src_a - src_b;
      OP_AND:  imm_result = src_a & src_b;
      OP_OR:   imm_result = src_a | src_b;
      OP_XOR:  imm_result = src_a ^ src_b;
      OP_SLT:  imm_result = {{(XLEN-1){1'b0}}, ($signed(src_a) < $signed(src_b))};
      OP_SLTU: imm_result = {{(XLEN-1){1'b0}}, (src_a < src_b)};
      OP_SLL,
      OP_SRL,
      OP_SRA:  imm_result = src_a;
      default: imm_illegal = 1'b1;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state and handshake outputs.
  always_comb begin
    next_state = state;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          next_state = start_shift ? SHIFT : DONE;
        end
      end
      SHIFT: begin
        // The edge that consumes the last bit of shifting enters DONE.
        if (count == SHAMT_W'(1)) begin
          next_state = DONE;
        end
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) begin
          next_state = IDLE;
        end
      end
      default: next_state = IDLE;
    endcase
  end

  // Operand capture and one-bit-per-cycle shifting.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      op_q    <= OP_ADD;
      result  <= '0;
      count   <= '0;
      illegal <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            op_q    <= alu_op;
            illegal <= imm_illegal;
            if (start_shift) begin
              result <= src_a;
              count  <= shamt;
            end else begin
              result <= imm_result;
              count  <= '0;
            end
          end
        end
        SHIFT: begin
          count <= count - SHAMT_W'(1);
          case (op_q)
            OP_SLL:  result <= {result[XLEN-2:0], 1'b0};
            OP_SRL:  result <= {1'b0, result[XLEN-1:1]};
            // MSB is never altered by an arithmetic right shift, so it still
            // holds the original sign bit.
            default: result <= {result[XLEN-1], result[XLEN-1:1]};
          endcase
        end
        default: ;
      endcase
    end
  end

  assign alu_result  = result;
  assign alu_zero    = (result == '0);
  assign alu_illegal = illegal;

endmodule
`default_nettype wire

// File: tb/tb_iterative_alu.sv
`default_nettype none
// ============================================================================
//  Module   : tb_iterative_alu
//  Brief    : Self-checking bench for iterative_alu with an expected-result
//             queue filled at request time and drained at result time.
//  Revision : 1.0  initial release
// ============================================================================
module tb_iterative_alu;

  localparam int XLEN = 32;

  typedef struct packed {
    logic [31:0] res;
    logic        zero;
    logic        ill;
    logic [7:0]  lat;
  } exp_t;

  logic            clk = 1'b0;
  logic            reset_n;
  logic            in_valid;
  logic            in_ready;
  logic [3:0]      alu_op;
  logic [XLEN-1:0] src_a;
  logic [XLEN-1:0] src_b;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] alu_result;
  logic            alu_zero;
  logic            alu_illegal;

  int   n_vec  = 0;
  int   n_fail = 0;
  exp_t sb[$];

  iterative_alu #(.XLEN(32), .SHAMT_W(5)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .alu_op     (alu_op),
    .src_a      (src_a),
    .src_b      (src_b),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .alu_result (alu_result),
    .alu_zero   (alu_zero),
    .alu_illegal(alu_illegal)
  );

  always #5 clk = ~clk;

  // Reference behaviour: results from whole-word operators, latency from op.
  function automatic exp_t model(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    exp_t              e;
    logic signed [31:0] sa;
    logic [4:0]        sh;
    sa = a;
    sh = b[4:0];
    e.ill = 1'b0;
    e.lat = 8'd1;
    case (op)
      4'd0: e.res = a + b;
      4'd1: e.res = a - b;
      4'd2: e.res = a & b;
      4'd3: e.res = a | b;
      4'd4: e.res = a ^ b;
      4'd5: e.res = ($signed(a) < $signed(b)) ? 32'h1 : 32'h0;
      4'd6: e.res = (a < b) ? 32'h1 : 32'h0;
      4'd7: e.res = a << sh;
      4'd8: e.res = a >> sh;
      4'd9: e.res = sa >>> sh;
      default: begin e.res = 32'h0; e.ill = 1'b1; end
    endcase
    if (op >= 4'd7 && op <= 4'd9 && sh != 5'd0) e.lat = 8'(sh) + 8'd1;
    e.zero = (e.res == 32'h0);
    return e;
  endfunction

  // Presents a request, waits (bounded) for acceptance, records the expected
  // result, then scrambles the operand inputs. Returns at posedge+1.
  task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    int guard = 0;
    alu_op   = op;
    src_a    = a;
    src_b    = b;
    in_valid = 1'b1;
    while (!in_ready && guard < 100) begin
      @(posedge clk); #1;
      guard++;
    end
    sb.push_back(model(op, a, b));
    @(posedge clk); #1;
    in_valid = 1'b0;
    alu_op   = 4'($urandom_range(0, 15));
    src_a    = $urandom;
    src_b    = $urandom;
  endtask

  // Waits (bounded) for out_valid, counting edges from acceptance; performs
  // the hand-off edge when out_ready is high.
  task automatic collect(output logic ov, output exp_t got);
    int lat = 1;
    while (!out_valid && lat < 200) begin
      @(posedge clk); #1;
      lat++;
    end
    ov      = out_valid;
    got.res = alu_result;
    got.zero = alu_zero;
    got.ill = alu_illegal;
    got.lat = 8'(lat);
    if (out_ready) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic run_op(input string name, input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    logic ov;
    exp_t got, exp;
    issue(op, a, b);
    collect(ov, got);
    exp = sb.pop_front();
    n_vec++;
    if ({ov, got} !== {1'b1, exp}) begin
      n_fail++;
      $display("FAIL %s: got valid=%0b res=%h zero=%0b ill=%0b lat=%0d, want valid=1 res=%h zero=%0b ill=%0b lat=%0d",
               name, ov, got.res, got.zero, got.ill, got.lat, exp.res, exp.zero, exp.ill, exp.lat);
    end
  endtask

  task automatic test_reset;
    reset_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    alu_op = '0; src_a = '0; src_b = '0;
    #2;
    n_vec++;
    if ({in_ready, out_valid, alu_result, alu_zero, alu_illegal} !== {1'b1, 1'b0, 32'h0, 1'b1, 1'b0}) begin
      n_fail++;
      $display("FAIL reset_values: got rdy=%0b vld=%0b res=%h zero=%0b ill=%0b, want 1 0 0 1 0",
               in_ready, out_valid, alu_result, alu_zero, alu_illegal);
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  task automatic test_add;
    run_op("add_5_7", 4'd0, 32'd5, 32'd7);
  endtask

  task automatic test_sub_slt;
    run_op("sub_3_3", 4'd1, 32'd3, 32'd3);
    run_op("slt_neg1_1", 4'd5, 32'hFFFF_FFFF, 32'd1);
    run_op("sltu_neg1_1", 4'd6, 32'hFFFF_FFFF, 32'd1);
    run_op("and", 4'd2, 32'hF0F0_1234, 32'h0FF0_FF00);
    run_op("or", 4'd3, 32'hF0F0_0000, 32'h0000_1234);
    run_op("xor", 4'd4, 32'hAAAA_5555, 32'hFFFF_0000);
  endtask

  task automatic test_shift;
    run_op("sra_by4", 4'd9, 32'h8000_0000, 32'd4);
    run_op("srl_by4", 4'd8, 32'h8000_0000, 32'd4);
    run_op("srl_by0", 4'd8, 32'hDEAD_BEEF, 32'hFFFF_FFE0);
    run_op("sll_by1", 4'd7, 32'hC000_0001, 32'd1);
  endtask

  task automatic test_backpressure;
    logic ov;
    exp_t got, exp;
    out_ready = 1'b0;
    issue(4'd7, 32'd1, 32'h0000_001F);
    collect(ov, got);
    exp = sb.pop_front();
    n_vec++;
    if ({ov, got} !== {1'b1, exp}) begin
      n_fail++;
      $display("FAIL sll_by31: got valid=%0b res=%h lat=%0d, want valid=1 res=%h lat=%0d",
               ov, got.res, got.lat, exp.res, exp.lat);
    end
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1; alu_op = 4'd0; src_a = 32'd9; src_b = 32'd9;
      @(posedge clk); #1;
      n_vec++;
      if ({out_valid, in_ready, alu_result, alu_illegal} !== {1'b1, 1'b0, 32'h8000_0000, 1'b0}) begin
        n_fail++;
        $display("FAIL hold_%0d: got vld=%0b rdy=%0b res=%h ill=%0b, want 1 0 80000000 0",
                 i, out_valid, in_ready, alu_result, alu_illegal);
      end
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    n_vec++;
    if ({out_valid, in_ready} !== 2'b01) begin
      n_fail++;
      $display("FAIL handoff_idle: got vld=%0b rdy=%0b, want vld=0 rdy=1", out_valid, in_ready);
    end
  endtask

  task automatic test_illegal;
    run_op("illegal_1111", 4'd15, 32'h1234_5678, 32'h9ABC_DEF0);
    run_op("after_illegal_add", 4'd0, 32'd10, 32'd20);
    run_op("illegal_1010", 4'd10, 32'hFFFF_FFFF, 32'd3);
  endtask

  task automatic test_reset_mid_shift;
    bit   seen = 1'b0;
    exp_t dropped;
    issue(4'd7, 32'h0000_0003, 32'd20);
    repeat (4) @(posedge clk);
    @(negedge clk);
    reset_n = 1'b0;
    #1;
    n_vec++;
    if ({in_ready, out_valid, alu_result, alu_zero, alu_illegal} !== {1'b1, 1'b0, 32'h0, 1'b1, 1'b0}) begin
      n_fail++;
      $display("FAIL mid_shift_reset: got rdy=%0b vld=%0b res=%h zero=%0b ill=%0b, want 1 0 0 1 0",
               in_ready, out_valid, alu_result, alu_zero, alu_illegal);
    end
    dropped = sb.pop_front();
    #1;
    reset_n = 1'b1;
    for (int i = 0; i < 25; i++) begin
      @(posedge clk); #1;
      if (out_valid) seen = 1'b1;
    end
    n_vec++;
    if (seen !== 1'b0) begin
      n_fail++;
      $display("FAIL abandoned_op: got out_valid seen=%0b, want 0 (dropped res %h)", seen, dropped.res);
    end
    run_op("add_after_reset", 4'd0, 32'd1, 32'd1);
  endtask

  task automatic test_back_to_back;
    for (int i = 0; i < 24; i++) begin
      logic [3:0]  op;
      logic [31:0] a, b;
      op = 4'($urandom_range(0, 11));
      a  = (i % 4 == 0) ? 32'h8000_0000 | $urandom : $urandom;
      b  = (i % 3 == 0) ? 32'($urandom_range(0, 31)) : $urandom;
      run_op($sformatf("rand_%0d_op%0d", i, op), op, a, b);
    end
  endtask

  initial begin
    test_reset;
    test_add;
    test_sub_slt;
    test_shift;
    test_backpressure;
    test_illegal;
    test_reset_mid_shift;
    test_back_to_back;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
